// File: rtl/io_irq_pkg.sv
// Shared types and constants for the processor I/O and interrupt port.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package io_irq_pkg;

   localparam int BYTE_W = 8;
   localparam logic [BYTE_W-1:0] ACK_CODE_DEF = 8'hFF;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQ      = 2'd1,
      WAIT_ACK = 2'd2,
      GAP      = 2'd3
   } irq_state_t;

endpackage

// File: rtl/io_irq_fifo.sv
// Small synchronous FIFO holding device bytes; head is shown first-word-fall-through.
// Latency: a pushed byte is visible on dout one cycle after the push edge when empty.
// Backpressure: push while full and pop while empty are ignored; full is combinational.
module io_irq_fifo
   import io_irq_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = BYTE_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == DEPTH[AW:0]);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Storage array; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/io_interrupt_port.sv
// Device-to-processor byte port: queues device bytes, interrupts per byte, waits for ISR ack; echoes processor bytes.
// Latency: byte pushed in cycle t shows on data_in with interrupt high in cycle t+2; echo strobe one cycle after data_out changes.
// Backpressure: dev_ready drops when the FIFO is full; optional IOIRQ_RETRY_STATS_EN adds retry_count and drop_flag.
module io_interrupt_port
   import io_irq_pkg::*;
#(
   parameter int                FIFO_DEPTH = 4,
   parameter logic [BYTE_W-1:0] ACK_CODE   = ACK_CODE_DEF,
   parameter int                IRQ_PULSE  = 2,
   parameter int                TIMEOUT    = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [BYTE_W-1:0] dev_data,
   input  logic              dev_valid,
   output logic              dev_ready,
   output logic [BYTE_W-1:0] data_in,
   output logic              interrupt,
`ifdef IOIRQ_RETRY_STATS_EN
   output logic [7:0]        retry_count,
   output logic [0:0]        drop_flag,
`endif
   input  logic [BYTE_W-1:0] data_out,
   output logic [BYTE_W-1:0] out_data,
   output logic              out_valid
);

   localparam int CNT_MAX = (TIMEOUT > IRQ_PULSE) ? TIMEOUT : IRQ_PULSE;
   localparam int CW      = $clog2(CNT_MAX + 1);

   irq_state_t        state, state_d;
   logic [CW-1:0]     cnt, cnt_d;
   logic              load;
   logic              pop;
   logic              timeout_hit;
   logic              ack;
   logic              full;
   logic              empty;
   logic [BYTE_W-1:0] fifo_dout;
   logic [BYTE_W-1:0] prev_data_out;

   assign dev_ready = !full;

   // Only the rising edge of an ACK match counts, so a held ACK acknowledges one byte.
   assign ack = (data_out == ACK_CODE) && (prev_data_out != ACK_CODE);

   io_irq_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (BYTE_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (dev_valid),
      .pop   (pop),
      .din   (dev_data),
      .dout  (fifo_dout),
      .full  (full),
      .empty (empty)
   );

   // Request sequencing: load head, pulse interrupt, wait for ack or re-issue on timeout.
   always_comb begin
      state_d     = state;
      cnt_d       = cnt;
      load        = 1'b0;
      pop         = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               load    = 1'b1;
               cnt_d   = '0;
               state_d = REQ;
            end
         end
         REQ: begin
            if (cnt == CW'(IRQ_PULSE - 1)) begin
               cnt_d   = '0;
               state_d = WAIT_ACK;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         WAIT_ACK: begin
            if (ack) begin
               pop     = 1'b1;
               cnt_d   = '0;
               state_d = GAP;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
               timeout_hit = 1'b1;
               cnt_d       = '0;
               state_d     = REQ;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         GAP: begin
            // Stay until the ACK code is gone so it cannot ack the next byte.
            if (data_out != ACK_CODE) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register plus registered interrupt and data_in (changes only on load).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         interrupt <= 1'b0;
         data_in   <= '0;
      end else begin
         state     <= state_d;
         cnt       <= cnt_d;
         interrupt <= (state_d == REQ);
         if (load) data_in <= fifo_dout;
      end
   end

   // Output echo: strobe on each change of data_out except into the ACK code.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_data_out <= ACK_CODE;
         out_data      <= '0;
         out_valid     <= 1'b0;
      end else begin
         prev_data_out <= data_out;
         if ((data_out != prev_data_out) && (data_out != ACK_CODE)) begin
            out_data  <= data_out;
            out_valid <= 1'b1;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef IOIRQ_RETRY_STATS_EN
   // Retry statistics: saturating timeout count and sticky overflow-drop flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         retry_count <= '0;
         drop_flag   <= 1'b0;
      end else begin
         if (timeout_hit && (retry_count != 8'hFF))
            retry_count <= retry_count + 1'b1;
         else if (pop && (retry_count != 8'hFF))
            retry_count <= '0;
         if (dev_valid && full) drop_flag <= 1'b1;
      end
   end
`endif

endmodule

// File: doc/io_interrupt_port.md
Name: io_interrupt_port

Overview:
- Peripheral-side counterpart of the 8-bit pipelined processor's I/O and interrupt interface.
- Buffers bytes from an external device in a small FIFO and presents the head byte on the processor's data_in.
- Raises the processor's interrupt line and waits for the ISR to acknowledge by writing ACK_CODE on data_out.
- Also forwards non-ACK processor output bytes to the device side as one-cycle strobes.

Parameters:
- FIFO_DEPTH, 4, device-byte FIFO entries; power of two, ≥2.
- ACK_CODE, 8'hFF, data_out value that acknowledges the current byte.
- IRQ_PULSE, 2, cycles interrupt is held high per request; ≥1.
- TIMEOUT, 64, cycles in WAIT_ACK before the request is re-issued; ≥4.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- dev_data  in  8  byte from the device.
- dev_valid  in  1  dev_data valid; accepted when dev_valid && dev_ready.
- dev_ready  out  1  FIFO not full; combinational from FIFO count.
- data_in  out  8  registered byte to the processor (head of FIFO).
- interrupt  out  1  registered interrupt request to the processor.
- data_out  in  8  processor output byte.
- out_data  out  8  last non-ACK byte written by the processor.
- out_valid  out  1  one-cycle strobe marking a new out_data.

Behaviour:
- Reset (async, active-high) clears FIFO, FSM→IDLE, all counters 0.
- Reset values: data_in=0, interrupt=0, out_data=0, out_valid=0; dev_ready=1 while reset is held.
- FIFO push: dev_valid && !full. Push while full is ignored; the byte is lost and the device must hold it.
- Simultaneous push and pop is allowed; count is unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, REQ, WAIT_ACK, GAP.
- IDLE: if FIFO non-empty, load head into data_in, clear counters, go to REQ next cycle.
- REQ: interrupt=1 for exactly IRQ_PULSE cycles (counter), then interrupt=0 and go to WAIT_ACK.
- WAIT_ACK, ack: ack is data_out==ACK_CODE && prev_data_out!=ACK_CODE (edge of the match; prev_data_out is a register). On ack, pop FIFO and go to GAP.
- WAIT_ACK, timeout: counter reaches TIMEOUT-1 with no ack → go to REQ and re-pulse interrupt. data_in is unchanged; no pop.
- GAP: wait until data_out!=ACK_CODE, then IDLE. This prevents a stale ACK from acknowledging the next byte.
- data_in changes only on the IDLE→REQ load. It is stable for the whole REQ/WAIT_ACK/GAP sequence.
- Latency: first byte pushed at cycle t gives data_in valid and interrupt=1 at t+2 (push t, IDLE sees non-empty t+1, REQ registered t+2).
- Output echo: when data_out!=prev_data_out && data_out!=ACK_CODE, out_data<=data_out and out_valid=1 for one cycle.
- Output echo detects changes only; a repeated identical byte does not re-strobe.
- An ACK edge never produces out_valid.
- The echo path operates in every FSM state.
- prev_data_out resets to ACK_CODE, so an ACK already present on data_out at reset release is not taken as an ack.

Optional Feature:
- Macro: IOIRQ_RETRY_STATS_EN.
- Defined: adds output retry_count [7:0], which increments on each WAIT_ACK timeout and saturates at 8'hFF. It clears on reset, and also clears on an ack unless saturated, in which case it is sticky until reset.
- Also adds output drop_flag [0:0], set when dev_valid arrives while full and cleared only by reset.
- Undefined: neither port exists; timeout behaviour is otherwise identical.

Decomposition:
- Package io_irq_pkg holds:
  - FSM state enum (IDLE, REQ, WAIT_ACK, GAP, 2-bit encoding);
  - default ACK_CODE constant 8'hFF;
  - byte width constant 8.
- Sub-module io_irq_fifo: synchronous FIFO with async active-high reset.
  - Parameter DEPTH.
  - Ports push/pop/din/dout/full/empty.
  - dout is the head, shown first-word-fall-through.
- The FSM, ack edge detect and output echo stay in the top module.

Test Plan:
1. Reset then push 8'h5A → interrupt high for 2 cycles starting 2 cycles after the push; data_in=8'h5A. Drive data_out=8'hFF → FIFO empty, FSM in GAP. Drive data_out=8'h00 → IDLE, interrupt stays 0.
2. Push 8'h11, 8'h22, 8'h33, 8'h44, 8'h55 back-to-back → dev_ready=0 after the 4th push and the 5th is dropped. Acking 4 times presents 11, 22, 33, 44 in order.
3. No ack after a push of 8'hA0 → interrupt re-pulses every 2+64 cycles and data_in stays 8'hA0. With IOIRQ_RETRY_STATS_EN, retry_count increments 1, 2, 3.
4. data_out held at 8'hFF across two queued bytes (8'h01, 8'h02) → only 8'h01 is popped; 8'h02 is not requested until data_out leaves 8'hFF.
5. data_out sequence 8'h10, 8'h10, 8'h20, 8'hFF → out_valid pulses twice, with out_data 8'h10 then 8'h20; the ACK produces no strobe.
6. Assert reset during WAIT_ACK with 3 bytes queued → interrupt=0, data_in=0 and dev_ready=1 immediately (async). After release, FIFO is empty and FSM is IDLE.
